sensor_debounce_pulse: RTL and testbench
========================================

Name: sensor_debounce_pulse

Overview:
- Input-side counterpart to the storage flip-flops of the bottling line.
- Takes a raw, asynchronous, bouncing bottle-presence sensor.
- Synchronises and debounces it, then emits a clean level plus a single-cycle pulse per confirmed rising edge.
- Keeps a saturating bottle counter that downstream control logic reads and clears.

Parameters:
- DEBOUNCE_CYCLES, 4, number N of consecutive identical synchronised samples needed to accept a level change; legal range 1..255.
- COUNT_WIDTH, 8, width of the bottle counter.

Ports:
- CLOCK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous reset, active high; sampled only on CLOCK rising edge.
- SENSOR  input  1  raw asynchronous sensor; 1 means bottle present.
- CLEAR  input  1  synchronous counter clear, active high.
- LEVEL  output  1  debounced sensor level, registered.
- PULSE  output  1  one-cycle high on each accepted 0->1 transition of LEVEL, registered.
- COUNT  output  COUNT_WIDTH  number of accepted rising edges, saturating.
- SAT  output  1  high while COUNT is all-ones, registered.

Behaviour:
- Interface: one clock, CLOCK. Reset is synchronous and active-high, RESET. Polarity and synchronicity are fixed.
- Reset: on a CLOCK edge with RESET=1, the following are cleared, and RESET overrides every other input:
  - sync stages s1 and s2 <= 0;
  - state <= LOW, debounce counter cnt <= 0;
  - LEVEL, PULSE, SAT <= 0, COUNT <= 0.
- Synchroniser: s1 <= SENSOR, s2 <= s1 on every edge. Only s2 feeds the FSM.
- FSM states (cnt width ceil(log2(N+1))):
  - LOW: if s2=1 and N=1, go to HIGH and assert a rise. If s2=1 and N>1, go to RISE_CHK with cnt <= 1. Else stay, cnt <= 0.
  - RISE_CHK: if s2=0, go to LOW with cnt <= 0. Else if cnt=N-1, go to HIGH and assert a rise. Else cnt <= cnt+1.
  - HIGH: if s2=0 and N=1, go to LOW with LEVEL <= 0. If s2=0 and N>1, go to FALL_CHK with cnt <= 1. Else stay.
  - FALL_CHK: if s2=1, go to HIGH with cnt <= 0. Else if cnt=N-1, go to LOW with LEVEL <= 0. Else cnt <= cnt+1.
- Rise: on the same edge, LEVEL <= 1, PULSE <= 1 and the counter update applies.
- PULSE is 0 on every edge that does not assert a rise, so it is never wider than one cycle.
- Falling transitions produce no pulse.
- Latency: let edge 0 be the edge where s1 first captures SENSOR=1 and SENSOR stays high. LEVEL and PULSE go high after edge N+1, i.e. edge 5 for N=4.
  - Falling: LEVEL goes low after edge N+1 from the first captured 0.
- Glitches: any glitch shorter than N samples of s2 returns the FSM to its stable state. It causes no LEVEL change and no PULSE.
- Counter, per edge, priority order:
  - CLEAR=1: COUNT <= 0. This wins over a simultaneous rise, and that rise is lost.
  - Else, on a rise with COUNT < max: COUNT <= COUNT+1.
  - Else, on a rise with COUNT = max: COUNT holds; PULSE still fires.
  - SAT = (COUNT == all-ones), registered together with COUNT.
- Reset mid-operation: debounce progress is discarded. If SENSOR is held high through reset, a fresh rise (PULSE, COUNT=1) occurs N+1 edges after the first post-reset edge that captures SENSOR into s1.
- CLEAR does not affect the FSM, LEVEL or PULSE.

Decomposition:
- Shared package vinho_pkg holds:
  - 2-bit state encodings LOW=0, RISE_CHK=1, HIGH=2, FALL_CHK=3;
  - default debounce and count-width constants used by the line controller.
- One sub-module: sync_2ff.
  - Two-stage synchroniser with synchronous active-high RESET.
  - Ports CLOCK, RESET, D, Q.
  - Instantiated once for SENSOR.

Test Plan:
- Reset with SENSOR=0, then hold SENSOR=1 from edge 0 (N=4) -> LEVEL=1 and PULSE=1 for exactly one cycle after edge 5; COUNT=1; PULSE=0 after edge 6.
- SENSOR=1 for 3 cycles then 0 (N=4) -> LEVEL stays 0, no PULSE, COUNT stays 0. Repeat with a 3-cycle low glitch while LEVEL=1 -> LEVEL stays 1.
- 255 clean rising edges (COUNT_WIDTH=8), then one more -> COUNT=255 and SAT=1 after the 255th rise; the 256th still gives PULSE but COUNT stays 255.
- CLEAR asserted on the same edge as a rise with COUNT=7 -> COUNT=0, PULSE=1; the next clean rise gives COUNT=1.
- RESET asserted while in RISE_CHK (cnt=2), SENSOR kept high -> all outputs 0 after the reset edge; PULSE reappears N+1 edges after the first post-reset capture; COUNT=1.
- N=1 configuration, a single-cycle SENSOR high -> PULSE exactly 2 edges after capture; LEVEL returns to 0 after the matching low is captured.

Source files
------------

// File: rtl/vinho_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vinho_pkg
// Description : Shared state encodings and default constants for the
//               bottling-line sensor front end.
// Revision    : 1.0 - initial release
// ============================================================================
package vinho_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } deb_state_e;

    localparam int c_DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int c_DEFAULT_COUNT_WIDTH     = 8;

endpackage
`default_nettype wire

// File: rtl/sensor_debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce_pulse_if
// Description : Sensor input, counter clear and debounced outputs of the
//               bottle-presence front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface sensor_debounce_pulse_if
    import vinho_pkg::*;
#(
    parameter int COUNT_WIDTH = c_DEFAULT_COUNT_WIDTH
);
    logic                   SENSOR;
    logic                   CLEAR;
    logic                   LEVEL;
    logic                   PULSE;
    logic [COUNT_WIDTH-1:0] COUNT;
    logic                   SAT;

    modport master (
        output SENSOR, CLEAR,
        input  LEVEL, PULSE, COUNT, SAT
    );

    modport slave (
        input  SENSOR, CLEAR,
        output LEVEL, PULSE, COUNT, SAT
    );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-stage synchroniser for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic CLOCK,
    input  wire logic RESET,
    input  wire logic D,
    output logic      Q
);
    logic r_s1;
    logic r_s2;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= D;
            r_s2 <= r_s1;
        end
    end

    assign Q = r_s2;
endmodule
`default_nettype wire

// File: rtl/sensor_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce_pulse
// Description : Synchronises and debounces a bottle-presence sensor, emits a
//               clean level, a one-cycle pulse per rise, and a saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce_pulse
    import vinho_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int COUNT_WIDTH     = c_DEFAULT_COUNT_WIDTH
)(
    input  wire logic               CLOCK,
    input  wire logic               RESET,
    sensor_debounce_pulse_if.slave  sio
);
    localparam int              c_CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = COUNT_WIDTH'(1);

    logic                   w_s2;
    deb_state_e             r_state;
    deb_state_e             w_state_nxt;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   r_pulse;
    logic                   w_rise;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic                   r_sat;

    sync_2ff u_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .D     (sio.SENSOR),
        .Q     (w_s2)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_rise;
            r_count <= w_count_nxt;
            r_sat   <= &w_count_nxt;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES identical samples.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise      = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_rise      = 1'b1;
                    end else begin
                        w_state_nxt = ST_RISE_CHK;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_RISE_CHK: begin
                if (!w_s2) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!w_s2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_FALL_CHK;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
            end
            ST_FALL_CHK: begin
                if (w_s2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
        endcase
    end

    // CLEAR beats a coincident rise; that rise is not counted.
    always_comb begin
        w_count_nxt = r_count;
        if (sio.CLEAR) begin
            w_count_nxt = '0;
        end else if (w_rise && !(&r_count)) begin
            w_count_nxt = r_count + c_COUNT_ONE;
        end
    end

    assign sio.LEVEL = r_level;
    assign sio.PULSE = r_pulse;
    assign sio.COUNT = r_count;
    assign sio.SAT   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_sensor_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_debounce_pulse
// Description : Self-checking bench for sensor_debounce_pulse (N=4 and N=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_debounce_pulse;
    localparam int N0   = 4;
    localparam int N1   = 1;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sen [2];
    logic clr [2];

    int checks   = 0;
    int failures = 0;

    // Reference: level flips after n consecutive sensor samples (seen two
    // edges late) that disagree with it; rises are counted, saturating.
    bit m_h1 [2];
    bit m_h2 [2];
    bit m_lvl [2];
    bit m_pulse [2];
    int m_run [2];
    int m_count [2];

    always #5 clk = ~clk;

    sensor_debounce_pulse_if #(.COUNT_WIDTH(CW)) bus0 ();
    sensor_debounce_pulse_if #(.COUNT_WIDTH(CW)) bus1 ();

    assign bus0.SENSOR = sen[0];
    assign bus0.CLEAR  = clr[0];
    assign bus1.SENSOR = sen[1];
    assign bus1.CLEAR  = clr[1];

    sensor_debounce_pulse #(.DEBOUNCE_CYCLES(N0), .COUNT_WIDTH(CW)) dut0 (
        .CLOCK (clk),
        .RESET (rst),
        .sio   (bus0)
    );

    sensor_debounce_pulse #(.DEBOUNCE_CYCLES(N1), .COUNT_WIDTH(CW)) dut1 (
        .CLOCK (clk),
        .RESET (rst),
        .sio   (bus1)
    );

    task automatic model_step(input int idx, input int n);
        bit obs;
        if (rst) begin
            m_h1[idx] = 0; m_h2[idx] = 0; m_lvl[idx] = 0;
            m_pulse[idx] = 0; m_run[idx] = 0; m_count[idx] = 0;
        end else begin
            obs = m_h2[idx];
            m_h2[idx] = m_h1[idx];
            m_h1[idx] = sen[idx];
            m_pulse[idx] = 0;
            m_run[idx] = (obs != m_lvl[idx]) ? m_run[idx] + 1 : 0;
            if (m_run[idx] == n) begin
                m_lvl[idx] = obs;
                m_pulse[idx] = obs;
                m_run[idx] = 0;
            end
            if (clr[idx]) m_count[idx] = 0;
            else if (m_pulse[idx] && m_count[idx] < CMAX) m_count[idx] = m_count[idx] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, N0);
        model_step(1, N1);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; sen[0] = 1'b1; sen[1] = 1'b1; clr[0] = 1'b0; clr[1] = 1'b0;
        ticks(3);
        checks++;
        if ({bus0.LEVEL, bus0.PULSE, bus0.SAT, bus0.COUNT} !== 11'd0) begin
            failures++;
            $display("FAIL reset_dut0 got L=%b P=%b S=%b C=%0d want all 0", bus0.LEVEL, bus0.PULSE, bus0.SAT, bus0.COUNT);
        end
        checks++;
        if ({bus1.LEVEL, bus1.PULSE, bus1.SAT, bus1.COUNT} !== 11'd0) begin
            failures++;
            $display("FAIL reset_dut1 got L=%b P=%b S=%b C=%0d want all 0", bus1.LEVEL, bus1.PULSE, bus1.SAT, bus1.COUNT);
        end
        rst = 1'b0; sen[0] = 1'b0; sen[1] = 1'b0;
        ticks(8);
        checks++;
        if ({bus0.LEVEL, bus0.PULSE, bus0.COUNT} !== 10'd0) begin
            failures++;
            $display("FAIL idle_after_reset got L=%b P=%b C=%0d want 0", bus0.LEVEL, bus0.PULSE, bus0.COUNT);
        end
    endtask

    task automatic test_clean_rise();
        sen[0] = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            checks++;
            if (bus0.LEVEL !== 1'b0 || bus0.PULSE !== 1'b0) begin
                failures++;
                $display("FAIL rise_early edge=%0d got L=%b P=%b want 0 0", e, bus0.LEVEL, bus0.PULSE);
            end
        end
        tick();
        checks++;
        if (bus0.LEVEL !== 1'b1 || bus0.PULSE !== 1'b1 || bus0.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL rise_edge5 got L=%b P=%b C=%0d want 1 1 1", bus0.LEVEL, bus0.PULSE, bus0.COUNT);
        end
        tick();
        checks++;
        if (bus0.LEVEL !== 1'b1 || bus0.PULSE !== 1'b0 || bus0.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL rise_edge6 got L=%b P=%b C=%0d want 1 0 1", bus0.LEVEL, bus0.PULSE, bus0.COUNT);
        end
        sen[0] = 1'b0;
        ticks(8);
        checks++;
        if (bus0.LEVEL !== 1'b0 || bus0.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL fall_clean got L=%b C=%0d want 0 1", bus0.LEVEL, bus0.COUNT);
        end
    endtask

    task automatic test_glitch();
        sen[0] = 1'b1; ticks(3); sen[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus0.LEVEL !== 1'b0 || bus0.PULSE !== 1'b0 || bus0.COUNT !== 8'd1) begin
                failures++;
                $display("FAIL high_glitch cyc=%0d got L=%b P=%b C=%0d want 0 0 1", i, bus0.LEVEL, bus0.PULSE, bus0.COUNT);
            end
        end
        sen[0] = 1'b1; ticks(8);
        checks++;
        if (bus0.LEVEL !== 1'b1 || bus0.COUNT !== 8'd2) begin
            failures++;
            $display("FAIL glitch_setup got L=%b C=%0d want 1 2", bus0.LEVEL, bus0.COUNT);
        end
        sen[0] = 1'b0; ticks(3); sen[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus0.LEVEL !== 1'b1 || bus0.PULSE !== 1'b0 || bus0.COUNT !== 8'd2) begin
                failures++;
                $display("FAIL low_glitch cyc=%0d got L=%b P=%b C=%0d want 1 0 2", i, bus0.LEVEL, bus0.PULSE, bus0.COUNT);
            end
        end
        sen[0] = 1'b0; ticks(8);
    endtask

    task automatic test_saturation();
        int hi;
        int lo;
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int r = 1; r <= 256; r++) begin
            hi = 0; lo = 0;
            sen[0] = 1'b1;
            for (int i = 0; i < 7; i++) begin tick(); hi += int'(bus0.PULSE); end
            sen[0] = 1'b0;
            for (int i = 0; i < 7; i++) begin tick(); lo += int'(bus0.PULSE); end
            checks++;
            if (hi != 1 || lo != 0) begin
                failures++;
                $display("FAIL sat_pulse rise=%0d got hi=%0d lo=%0d want 1 0", r, hi, lo);
            end
            if (r == 254 || r == 255 || r == 256) begin
                checks++;
                if (bus0.COUNT !== 8'((r > CMAX) ? CMAX : r) || bus0.SAT !== (r >= CMAX)) begin
                    failures++;
                    $display("FAIL sat_count rise=%0d got C=%0d S=%b want C=%0d S=%b", r, bus0.COUNT, bus0.SAT, (r > CMAX) ? CMAX : r, r >= CMAX);
                end
            end
        end
    endtask

    task automatic test_clear_collision();
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int r = 0; r < 7; r++) begin
            sen[0] = 1'b1; ticks(7); sen[0] = 1'b0; ticks(7);
        end
        checks++;
        if (bus0.COUNT !== 8'd7 || bus0.SAT !== 1'b0) begin
            failures++;
            $display("FAIL clr_setup got C=%0d S=%b want 7 0", bus0.COUNT, bus0.SAT);
        end
        sen[0] = 1'b1; ticks(5);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        checks++;
        if (bus0.PULSE !== 1'b1 || bus0.LEVEL !== 1'b1 || bus0.COUNT !== 8'd0) begin
            failures++;
            $display("FAIL clr_vs_rise got P=%b L=%b C=%0d want 1 1 0", bus0.PULSE, bus0.LEVEL, bus0.COUNT);
        end
        tick(); sen[0] = 1'b0; ticks(7);
        sen[0] = 1'b1; ticks(7);
        checks++;
        if (bus0.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL clr_next_rise got C=%0d want 1", bus0.COUNT);
        end
        sen[0] = 1'b0; ticks(8);
    endtask

    task automatic test_reset_midway();
        sen[0] = 1'b1; ticks(4);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({bus0.LEVEL, bus0.PULSE, bus0.SAT, bus0.COUNT} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset got L=%b P=%b S=%b C=%0d want all 0", bus0.LEVEL, bus0.PULSE, bus0.SAT, bus0.COUNT);
        end
        for (int e = 0; e < 5; e++) begin
            tick();
            checks++;
            if (bus0.PULSE !== 1'b0 || bus0.LEVEL !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_early edge=%0d got P=%b L=%b want 0 0", e, bus0.PULSE, bus0.LEVEL);
            end
        end
        tick();
        checks++;
        if (bus0.PULSE !== 1'b1 || bus0.LEVEL !== 1'b1 || bus0.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL post_reset_rise got P=%b L=%b C=%0d want 1 1 1", bus0.PULSE, bus0.LEVEL, bus0.COUNT);
        end
        sen[0] = 1'b0; ticks(8);
    endtask

    task automatic test_n1();
        sen[1] = 1'b1; tick(); sen[1] = 1'b0; tick();
        checks++;
        if (bus1.PULSE !== 1'b0 || bus1.LEVEL !== 1'b0) begin
            failures++;
            $display("FAIL n1_edge1 got P=%b L=%b want 0 0", bus1.PULSE, bus1.LEVEL);
        end
        tick();
        checks++;
        if (bus1.PULSE !== 1'b1 || bus1.LEVEL !== 1'b1 || bus1.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL n1_edge2 got P=%b L=%b C=%0d want 1 1 1", bus1.PULSE, bus1.LEVEL, bus1.COUNT);
        end
        tick();
        checks++;
        if (bus1.PULSE !== 1'b0 || bus1.LEVEL !== 1'b0 || bus1.COUNT !== 8'd1) begin
            failures++;
            $display("FAIL n1_edge3 got P=%b L=%b C=%0d want 0 0 1", bus1.PULSE, bus1.LEVEL, bus1.COUNT);
        end
        ticks(4);
    endtask

    task automatic test_random();
        logic [10:0] act0, act1, exp0, exp1;
        for (int c = 0; c < 1500; c++) begin
            // Alternate between bouncy and calm phases so both glitches and real edges occur.
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, ((c / 100) % 2 == 0) ? 2 : 9) == 0) sen[k] = ~sen[k];
                clr[k] = ($urandom_range(0, 40) == 0);
            end
            rst = ($urandom_range(0, 300) == 0);
            tick();
            act0 = {bus0.LEVEL, bus0.PULSE, bus0.SAT, bus0.COUNT};
            exp0 = {m_lvl[0], m_pulse[0], m_count[0] == CMAX, 8'(m_count[0])};
            act1 = {bus1.LEVEL, bus1.PULSE, bus1.SAT, bus1.COUNT};
            exp1 = {m_lvl[1], m_pulse[1], m_count[1] == CMAX, 8'(m_count[1])};
            checks++;
            if (act0 !== exp0) begin
                failures++;
                $display("FAIL rand_n4 cyc=%0d got LPSC=%b want %b", c, act0, exp0);
            end
            checks++;
            if (act1 !== exp1) begin
                failures++;
                $display("FAIL rand_n1 cyc=%0d got LPSC=%b want %b", c, act1, exp1);
            end
        end
        rst = 1'b0; clr[0] = 1'b0; clr[1] = 1'b0;
    endtask

    initial begin
        sen[0] = 1'b0; sen[1] = 1'b0; clr[0] = 1'b0; clr[1] = 1'b0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_saturation();
        test_clear_collision();
        test_reset_midway();
        test_n1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
